vu_lane_xbar_pipe: RTL and testbench
====================================

# vu_lane_xbar_pipe

Parametrised, registered read crossbar for a banked vector lane: routes per-bank read data (or per-bank operand latches) to NPORT functional-unit read ports under one-hot bank enables, with one pipeline stage, per-port hold, per-port valid and sticky multi-driver conflict detection. It sits between the lane's register-file banks and the functional-unit operand inputs, replacing the fixed 8x8 purely combinational bank-to-port crossbar.

## Interface
- NBANK, 8, number of register-file banks (1..16)
- NPORT, 8, number of read ports (1..16)
- DATA_W, 65, data width per bank/port
- SRC_SEL, 16'h0061, 2 bits per port (port p at [2p+1:2p]): 0 = rdata, 1 = ropl0, 2 = ropl1, 3 = port disabled; default gives port0 ropl0, port2 ropl1, port3 ropl0, all others rdata
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high; clears all state immediately
- rblen  in  NBANK*NPORT  bank enables; bit b*NPORT+p = bank b drives port p
- rdata  in  NBANK*DATA_W  bank read data; bank b at [b*DATA_W +: DATA_W]
- ropl0  in  NBANK*DATA_W  per-bank operand latch 0, same packing
- ropl1  in  NBANK*DATA_W  per-bank operand latch 1, same packing
- hold  in  NPORT  per-port stall; 1 = port register keeps its contents
- err_clr  in  1  clears sticky conflict state
- rbl  out  NPORT*DATA_W  registered port data; port p at [p*DATA_W +: DATA_W]
- rbl_val  out  NPORT  registered per-port valid
- conflict_port  out  NPORT  sticky per-port conflict mask
- conflict_err  out  1  OR of conflict_port

## Operation
- Per port p, source vector S_p = rdata/ropl0/ropl1 per SRC_SEL[2p+1:2p].
- Next data D_p = OR over b of ({DATA_W{rblen[b*NPORT+p]}} & S_p[b]); next valid V_p = OR over b of rblen[b*NPORT+p].
- hold[p]=0: rbl_p <= D_p, rbl_val[p] <= V_p. hold[p]=1: rbl_p and rbl_val[p] unchanged, enables for p ignored (no conflict check).
- No enable to p and hold[p]=0: rbl_p <= 0, rbl_val[p] <= 0 (output zeroed, not held).
- Conflict: hold[p]=0 and more than one rblen bit for p set -> conflict_port[p] <= 1. Data still the bitwise OR of all enabled sources, rbl_val[p]=1.
- err_clr=1: conflict_port <= 0, except bits newly set the same cycle (set wins over clear).
- SRC_SEL code 3: rbl_p, rbl_val[p], conflict_port[p] constant 0; enables ignored.
- conflict_err combinational OR of registered conflict_port.
- No backpressure: enables are consumed every non-held cycle; upstream owns one-hotness.

## Timing
- Reset values: rbl=0, rbl_val=0, conflict_port=0, conflict_err=0; asserted asynchronously, released synchronously by the enclosing design.
- Latency: enables/data sampled at edge N appear on rbl/rbl_val after edge N (1 cycle); conflict_port also visible after edge N.
- hold sampled on the same edge as data; holding at edge N keeps the value loaded at edge N-1 or earlier, indefinitely.
- Ports are independent: hold on one port never affects another; same bank may drive multiple ports in one cycle (legal, no conflict).
- Reset mid-hold or mid-conflict: everything cleared; first post-reset edge behaves as from idle.

## Test plan
- Default params, rblen bank3->port1 only, rdata[3]=65'h1_2345_6789_ABCD_EF01 -> one cycle later rbl port1 = that value, rbl_val=8'b0000_0010, others 0, conflict_err=0.
- Source mapping: bank5 enabled to ports 0,2,4 with ropl0[5]=A, ropl1[5]=B, rdata[5]=C -> port0=A, port2=B, port4=C, all valid, no conflict (fan-out legal).
- Hold: load port6 with 0x55, then hold[6]=1 for 3 cycles with bank0->port6 enable and rdata[0]=0xAA -> port6 stays 0x55 valid; release -> 0xAA next cycle.
- Conflict: banks 1 and 2 -> port7 with 0x0F0 and 0x00F -> rbl port7=0x0FF, conflict_port=8'h80, conflict_err=1; stays set after enables drop; err_clr -> clears next cycle; err_clr concurrent with new conflict on port7 -> stays 1.
- Parametrised build NBANK=4, NPORT=3, DATA_W=32, SRC_SEL=6'b11_00_01 -> port2 always 0/invalid; port0 follows ropl0, port1 follows rdata; random one-hot traffic checked against reference model.
- Assert reset mid-traffic with valid ports and a pending conflict -> all outputs 0 immediately, without waiting for clk.

Source files
------------

// File: rtl/vu_lane_xbar_pipe.sv
// Registered bank-to-port read crossbar for a banked vector lane, with per-port hold, valid and sticky conflict flags.
// Latency: 1 cycle from rblen/rdata/ropl* sampled at a rising edge to rbl/rbl_val/conflict_port.
// Backpressure: none; enables are consumed on every non-held cycle, and hold freezes only its own port.
module vu_lane_xbar_pipe #(
   parameter int                  NBANK   = 8,
   parameter int                  NPORT   = 8,
   parameter int                  DATA_W  = 65,
   parameter logic [2*NPORT-1:0]  SRC_SEL = 16'h0061
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [NBANK*NPORT-1:0]   rblen,
   input  logic [NBANK*DATA_W-1:0]  rdata,
   input  logic [NBANK*DATA_W-1:0]  ropl0,
   input  logic [NBANK*DATA_W-1:0]  ropl1,
   input  logic [NPORT-1:0]         hold,
   input  logic                     err_clr,
   output logic [NPORT*DATA_W-1:0]  rbl,
   output logic [NPORT-1:0]         rbl_val,
   output logic [NPORT-1:0]         conflict_port,
   output logic                     conflict_err
);

   localparam logic [1:0] SEL_RDATA = 2'd0;
   localparam logic [1:0] SEL_ROPL0 = 2'd1;
   localparam logic [1:0] SEL_ROPL1 = 2'd2;
   localparam logic [1:0] SEL_OFF   = 2'd3;

   // Each port is an independent slice: its source is fixed at build time,
   // so the mux below collapses to wiring and only the bank OR-tree remains.
   for (genvar p = 0; p < NPORT; p++) begin : g_port
      localparam logic [1:0] SEL = SRC_SEL[2*p +: 2];

      if (SEL == SEL_OFF) begin : g_off
         // Disabled port: outputs are tied low, enables and hold have no effect.
         assign rbl[p*DATA_W +: DATA_W] = '0;
         assign rbl_val[p]              = 1'b0;
         assign conflict_port[p]        = 1'b0;
      end else begin : g_on
         logic [NBANK*DATA_W-1:0] src_vec;
         logic [DATA_W-1:0]       d_nxt;
         logic                    v_nxt;
         logic                    multi_nxt;
         logic [DATA_W-1:0]       data_q;
         logic                    val_q;
         logic                    conf_q;

         if (SEL == SEL_ROPL0) begin : g_src_ropl0
            assign src_vec = ropl0;
         end else if (SEL == SEL_ROPL1) begin : g_src_ropl1
            assign src_vec = ropl1;
         end else begin : g_src_rdata
            assign src_vec = rdata;
         end

         // OR together every enabled bank; flag a second enable as a conflict.
         always_comb begin
            d_nxt     = '0;
            v_nxt     = 1'b0;
            multi_nxt = 1'b0;
            for (int b = 0; b < NBANK; b++) begin
               if (rblen[b*NPORT + p]) begin
                  multi_nxt = multi_nxt | v_nxt;
                  v_nxt     = 1'b1;
                  d_nxt     = d_nxt | src_vec[b*DATA_W +: DATA_W];
               end
            end
         end

         // Port register: load (or zero when undriven) unless held; held
         // cycles skip the conflict check, and a new conflict beats err_clr.
         always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
               data_q <= '0;
               val_q  <= 1'b0;
               conf_q <= 1'b0;
            end else begin
               if (!hold[p]) begin
                  data_q <= d_nxt;
                  val_q  <= v_nxt;
               end
               if (!hold[p] && multi_nxt) begin
                  conf_q <= 1'b1;
               end else if (err_clr) begin
                  conf_q <= 1'b0;
               end
            end
         end

         assign rbl[p*DATA_W +: DATA_W] = data_q;
         assign rbl_val[p]              = val_q;
         assign conflict_port[p]        = conf_q;
      end
   end

   assign conflict_err = |conflict_port;

endmodule

// File: tb/tb_vu_lane_xbar_pipe.sv
module tb_vu_lane_xbar_pipe;

   // default build
   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic [63:0]   rblen;
   logic [519:0]  rdata, ropl0, ropl1;
   logic [7:0]    hold;
   logic          err_clr;
   logic [519:0]  rbl;
   logic [7:0]    rbl_val, conflict_port;
   logic          conflict_err;

   // NBANK=4, NPORT=3, DATA_W=32 build
   logic [11:0]   p_rblen;
   logic [127:0]  p_rdata, p_ropl0, p_ropl1;
   logic [2:0]    p_hold;
   logic          p_err_clr;
   logic [95:0]   p_rbl;
   logic [2:0]    p_val, p_cp;
   logic          p_err;

   int checks = 0;
   int failures = 0;

   logic [519:0] tmp;
   logic [31:0]  e0, e1;
   int           pick [2];

   localparam logic [64:0] V_T1 = 65'h1_2345_6789_ABCD_EF01;
   localparam logic [64:0] V_A  = 65'h1_0000_0000_0000_00A1;
   localparam logic [64:0] V_B  = 65'h0_8000_0000_0000_00B2;
   localparam logic [64:0] V_C  = 65'h0_0000_C0C0_0000_00C3;

   vu_lane_xbar_pipe u_dut (
      .clk(clk), .reset(reset), .rblen(rblen), .rdata(rdata), .ropl0(ropl0),
      .ropl1(ropl1), .hold(hold), .err_clr(err_clr), .rbl(rbl), .rbl_val(rbl_val),
      .conflict_port(conflict_port), .conflict_err(conflict_err)
   );

   vu_lane_xbar_pipe #(.NBANK(4), .NPORT(3), .DATA_W(32), .SRC_SEL(6'b11_00_01)) u_dut_p (
      .clk(clk), .reset(reset), .rblen(p_rblen), .rdata(p_rdata), .ropl0(p_ropl0),
      .ropl1(p_ropl1), .hold(p_hold), .err_clr(p_err_clr), .rbl(p_rbl), .rbl_val(p_val),
      .conflict_port(p_cp), .conflict_err(p_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rblen = '0; rdata = '0; ropl0 = '0; ropl1 = '0; hold = '0; err_clr = 1'b0;
      p_rblen = '0; p_rdata = '0; p_ropl0 = '0; p_ropl1 = '0; p_hold = '0; p_err_clr = 1'b0;

      // reset state
      #1 reset = 1'b1;
      #1;
      chk("rst_rbl_any", |rbl, 0);
      chk("rst_val", rbl_val, 0);
      chk("rst_cp", conflict_port, 0);
      chk("rst_err", conflict_err, 0);
      @(negedge clk) reset = 1'b0;

      // single bank to single port
      rdata[3*65 +: 65] = V_T1;
      rblen[3*8 + 1] = 1'b1;
      tick();
      chk("t1_port1", rbl[1*65 +: 65], V_T1);
      chk("t1_val", rbl_val, 8'b0000_0010);
      tmp = rbl; tmp[1*65 +: 65] = '0;
      chk("t1_others", |tmp, 0);
      chk("t1_err", conflict_err, 0);

      // source mapping with fan-out of one bank
      rblen = '0;
      ropl0[5*65 +: 65] = V_A;
      ropl1[5*65 +: 65] = V_B;
      rdata[5*65 +: 65] = V_C;
      rblen[5*8 + 0] = 1'b1; rblen[5*8 + 2] = 1'b1; rblen[5*8 + 4] = 1'b1;
      tick();
      chk("map_port0", rbl[0*65 +: 65], V_A);
      chk("map_port2", rbl[2*65 +: 65], V_B);
      chk("map_port4", rbl[4*65 +: 65], V_C);
      chk("map_port1_zeroed", rbl[1*65 +: 65], 0);
      chk("map_val", rbl_val, 8'b0001_0101);
      chk("map_cp", conflict_port, 0);

      // hold on port6, port5 keeps moving
      rblen = '0;
      rdata[0*65 +: 65] = 65'h55;
      rblen[0*8 + 6] = 1'b1;
      tick();
      chk("hold_load", rbl[6*65 +: 65], 65'h55);
      chk("hold_load_val", rbl_val, 8'h40);
      rdata[0*65 +: 65] = 65'hAA;
      rblen[0*8 + 5] = 1'b1;
      hold[6] = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("hold_port6", rbl[6*65 +: 65], 65'h55);
         chk("hold_val", rbl_val, 8'h60);
         chk("hold_port5", rbl[5*65 +: 65], 65'hAA);
      end
      hold[6] = 1'b0;
      tick();
      chk("hold_release", rbl[6*65 +: 65], 65'hAA);

      // conflict on port7
      rblen = '0;
      rdata[1*65 +: 65] = 65'h0F0;
      rdata[2*65 +: 65] = 65'h00F;
      rblen[1*8 + 7] = 1'b1; rblen[2*8 + 7] = 1'b1;
      tick();
      chk("conf_data", rbl[7*65 +: 65], 65'h0FF);
      chk("conf_val", rbl_val, 8'h80);
      chk("conf_cp", conflict_port, 8'h80);
      chk("conf_err", conflict_err, 1);
      rblen = '0;
      tick();
      chk("conf_sticky", conflict_port, 8'h80);
      chk("conf_drop_val", rbl_val, 0);
      chk("conf_drop_data", rbl[7*65 +: 65], 0);
      err_clr = 1'b1;
      tick();
      chk("conf_clr_cp", conflict_port, 0);
      chk("conf_clr_err", conflict_err, 0);
      err_clr = 1'b0;
      rblen[1*8 + 7] = 1'b1; rblen[2*8 + 7] = 1'b1;
      tick();
      chk("conf_reset_again", conflict_port, 8'h80);
      err_clr = 1'b1;
      tick();
      chk("conf_set_wins", conflict_port, 8'h80);
      chk("conf_set_wins_err", conflict_err, 1);
      rblen = '0;
      tick();
      chk("conf_clr2", conflict_port, 0);
      err_clr = 1'b0;
      hold[7] = 1'b1;
      rblen[1*8 + 7] = 1'b1; rblen[2*8 + 7] = 1'b1;
      tick();
      chk("conf_held_ignored", conflict_port, 0);
      chk("conf_held_data", rbl[7*65 +: 65], 0);
      hold[7] = 1'b0;

      // asynchronous reset mid-traffic
      rblen[3*8 + 1] = 1'b1;
      tick();
      chk("pre_rst_err", conflict_err, 1);
      chk("pre_rst_val", rbl_val, 8'h82);
      #2 reset = 1'b1;
      #1;
      chk("arst_rbl_any", |rbl, 0);
      chk("arst_val", rbl_val, 0);
      chk("arst_cp", conflict_port, 0);
      chk("arst_err", conflict_err, 0);
      rblen = '0;
      @(negedge clk) reset = 1'b0;
      tick();
      chk("post_rst_val", rbl_val, 0);
      chk("post_rst_cp", conflict_port, 0);

      // parametrised build, random one-hot traffic against a reference model
      for (int it = 0; it < 24; it++) begin
         for (int b = 0; b < 4; b++) begin
            p_rdata[b*32 +: 32] = $urandom;
            p_ropl0[b*32 +: 32] = $urandom;
            p_ropl1[b*32 +: 32] = $urandom;
         end
         p_rblen = '0;
         for (int p = 0; p < 2; p++) begin
            pick[p] = $urandom_range(0, 4);
            if (pick[p] < 4) p_rblen[pick[p]*3 + p] = 1'b1;
         end
         for (int b = 0; b < 4; b++) p_rblen[b*3 + 2] = 1'($urandom_range(0, 1));
         tick();
         e0 = (pick[0] < 4) ? p_ropl0[pick[0]*32 +: 32] : 32'h0;
         e1 = (pick[1] < 4) ? p_rdata[pick[1]*32 +: 32] : 32'h0;
         chk("p_port0", p_rbl[0 +: 32], e0);
         chk("p_port1", p_rbl[32 +: 32], e1);
         chk("p_port2", p_rbl[64 +: 32], 0);
         chk("p_val", p_val, {1'b0, pick[1] < 4, pick[0] < 4});
         chk("p_cp", p_cp, 0);
         chk("p_err", p_err, 0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
